// File: rtl/act_lut_pkg.sv
// Shared constants and state encoding for the activation LUT writer and the interpolator.
package act_lut_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int SEG_BITS_DEF = 4;
   localparam int N_ENTRIES    = 2**SEG_BITS_DEF + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      ERR   = 2'd3
   } lut_state_t;

endpackage

// File: rtl/act_lut_regfile.sv
// Breakpoint register file: one write port, registered paired read of entry[a] and entry[a+1].
module act_lut_regfile
   import act_lut_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SEG_BITS = SEG_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [SEG_BITS:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic                rd_zero,
   input  logic [SEG_BITS-1:0] raddr,
   output logic [DATA_W-1:0]   rd_base,
   output logic [DATA_W-1:0]   rd_next
);

   localparam int N = 2**SEG_BITS + 1;

   logic [N-1:0][DATA_W-1:0] mem;
   logic [SEG_BITS:0]        ra_base;
   logic [SEG_BITS:0]        ra_next;

   // The +1 is done one bit wider so the top segment reaches the extra entry instead of wrapping.
   assign ra_base = {1'b0, raddr};
   assign ra_next = ra_base + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we && (waddr == (SEG_BITS+1)'(i))) mem[i] <= wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_base <= '0;
         rd_next <= '0;
      end else if (re) begin
         rd_base <= rd_zero ? '0 : mem[ra_base];
         rd_next <= rd_zero ? '0 : mem[ra_next];
      end
   end

endmodule

// File: rtl/act_lut_writer.sv
// Loads 2**SEG_BITS+1 breakpoints over a valid/ready stream, checks the load length,
// and serves base/next pairs to the interpolator only while a complete table is held.
module act_lut_writer
   import act_lut_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SEG_BITS = SEG_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic                s_last,
   output logic                table_valid,
   output logic                load_err,
   input  logic                rd_en,
   input  logic [SEG_BITS-1:0] rd_addr,
   output logic                rd_valid,
   output logic [DATA_W-1:0]   rd_base,
   output logic [DATA_W-1:0]   rd_next
);

   localparam int                IDX_W    = SEG_BITS + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2**SEG_BITS);

   lut_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             accept;
   logic             wr_en;
   logic             rd_vld_q;

   assign accept = s_valid && s_ready;
   // A restart discards any beat landing in the same cycle.
   assign wr_en  = accept && !start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rd_vld_q <= rd_en;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      s_ready     = 1'b0;
      table_valid = 1'b0;
      load_err    = 1'b0;
      case (state_q)
         LOAD:    s_ready     = 1'b1;
         READY:   table_valid = 1'b1;
         ERR:     load_err    = 1'b1;
         default: ;
      endcase
      if (start) begin
         state_d = LOAD;
         idx_d   = '0;
      end else if (state_q == LOAD && accept) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == LAST_IDX) state_d = s_last ? READY : ERR;
         else if (s_last)       state_d = ERR;
      end
   end

   act_lut_regfile #(
      .DATA_W   (DATA_W),
      .SEG_BITS (SEG_BITS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en),
      .waddr   (idx_q),
      .wdata   (s_data),
      .re      (rd_en),
      .rd_zero (!table_valid),
      .raddr   (rd_addr),
      .rd_base (rd_base),
      .rd_next (rd_next)
   );

   assign rd_valid = rd_vld_q;

endmodule

// File: tb/tb_act_lut_writer.sv
// Directed bench for act_lut_writer: load length checks, back-pressure, restart, reset and reads.
module tb_act_lut_writer;

   logic       clk = 1'b0;
   logic       rst, start, s_valid, s_last, rd_en;
   logic [7:0] s_data;
   logic [3:0] rd_addr;
   logic       s_ready, table_valid, load_err, rd_valid;
   logic [7:0] rd_base, rd_next;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   act_lut_writer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .table_valid (table_valid),
      .load_err    (load_err),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_base     (rd_base),
      .rd_next     (rd_next)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int v, input logic last);
      s_valid = 1'b1;
      s_data  = 8'(v);
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic rd(input string tag, input int a, input int eb, input int en);
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      tick();
      rd_en   = 1'b0;
      chk({tag, "_vld"},  int'(rd_valid), 1);
      chk({tag, "_base"}, int'($signed(rd_base)), eb);
      chk({tag, "_next"}, int'($signed(rd_next)), en);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      s_data = '0; rd_en = 1'b0; rd_addr = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_ready", int'(s_ready), 0);
      chk("rst_tv",    int'(table_valid), 0);
      chk("rst_err",   int'(load_err), 0);
      chk("rst_rvld",  int'(rd_valid), 0);
      chk("rst_base",  int'(rd_base), 0);
      chk("rst_next",  int'(rd_next), 0);
      rd("pre_rd", 3, 0, 0);

      // Normal load, entry i = 8*i-64; read issued alongside the final beat sees zeros.
      do_start();
      chk("norm_ready", int'(s_ready), 1);
      for (int i = 0; i < 16; i++) send(8*i - 64, 1'b0);
      chk("norm_tv16", int'(table_valid), 0);
      rd_en = 1'b1; rd_addr = 4'd3;
      send(64, 1'b1);
      rd_en = 1'b0;
      chk("same_cyc_base", int'(rd_base), 0);
      chk("same_cyc_next", int'(rd_next), 0);
      chk("norm_tv",    int'(table_valid), 1);
      chk("norm_err",   int'(load_err), 0);
      chk("norm_sr",    int'(s_ready), 0);
      rd("norm_a3",  3, -40, -32);
      rd("norm_a15", 15, 56, 64);
      rd("norm_a0",  0, -64, -56);
      // Back-to-back pipelined reads
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      chk("pipe1_base", int'($signed(rd_base)), -56);
      rd_addr = 4'd9;
      tick();
      rd_en = 1'b0;
      chk("pipe2_base", int'($signed(rd_base)), 8);
      chk("pipe2_next", int'($signed(rd_next)), 16);
      tick();
      chk("rvld_drop", int'(rd_valid), 0);

      // Short load: last on beat 9
      do_start();
      chk("short_tv_drop", int'(table_valid), 0);
      for (int i = 0; i < 10; i++) send(i, i == 9);
      chk("short_err", int'(load_err), 1);
      chk("short_tv",  int'(table_valid), 0);
      chk("short_sr",  int'(s_ready), 0);
      tick(); tick();
      chk("short_sticky", int'(load_err), 1);
      rd("short_rd", 3, 0, 0);

      // Long load: 17 beats, none marked last
      do_start();
      chk("long_err_clr", int'(load_err), 0);
      for (int i = 0; i < 16; i++) send(i + 1, 1'b0);
      chk("long_err16", int'(load_err), 0);
      chk("long_sr16",  int'(s_ready), 1);
      send(17, 1'b0);
      chk("long_err", int'(load_err), 1);
      chk("long_tv",  int'(table_valid), 0);
      do_start();
      chk("reload_err_clr", int'(load_err), 0);
      for (int i = 0; i < 17; i++) send(3*i - 20, i == 16);
      chk("reload_tv",  int'(table_valid), 1);
      chk("reload_err", int'(load_err), 0);
      rd("reload_a7", 7, 1, 4);

      // Back-pressure: idle cycle between every beat
      do_start();
      for (int i = 0; i < 17; i++) begin
         send(40 - 5*i, i == 16);
         if (i == 15) chk("bp_tv_gap", int'(table_valid), 0);
         if (i < 16) tick();
      end
      chk("bp_tv",  int'(table_valid), 1);
      chk("bp_err", int'(load_err), 0);
      rd("bp_a10", 10, -10, -15);
      rd("bp_a15", 15, -35, -40);

      // Restart at beat 8 with a beat in flight, then a full reload
      do_start();
      for (int i = 0; i < 8; i++) send(90 + i, 1'b0);
      start = 1'b1; s_valid = 1'b1; s_data = 8'd99;
      tick();
      start = 1'b0; s_valid = 1'b0;
      chk("rs_sr", int'(s_ready), 1);
      for (int i = 0; i < 17; i++) send(7*i - 60, i == 16);
      chk("rs_tv",  int'(table_valid), 1);
      chk("rs_err", int'(load_err), 0);
      rd("rs_a0", 0, -60, -53);
      rd("rs_a8", 8, -4, 3);

      // Reset at beat 5 of a new load
      do_start();
      for (int i = 0; i < 5; i++) send(50 + i, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_sr",   int'(s_ready), 0);
      chk("mrst_tv",   int'(table_valid), 0);
      chk("mrst_err",  int'(load_err), 0);
      chk("mrst_rvld", int'(rd_valid), 0);
      chk("mrst_base", int'(rd_base), 0);
      chk("mrst_next", int'(rd_next), 0);
      tick();
      chk("mrst_idle", int'(s_ready), 0);
      rd("mrst_a3",  3, 0, 0);
      rd("mrst_a15", 15, 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
